// File: rtl/edge_threshold_if.sv
// Pixel stream bundle between sobel_filter and edge_threshold.
// The slave side is the thresholding stage; the master side feeds magnitudes and observes the edge map.
// There is no ready signal: valid_in alone qualifies pixel_in, and the consumer must absorb every valid beat.
interface edge_threshold_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] pixel_in;
  logic             valid_in;
  logic [WIDTH-1:0] pixel_out;
  logic             valid_out;
  logic             sof;
  logic             eol;
  logic             eof;

  modport master (
    output pixel_in, valid_in,
    input  pixel_out, valid_out, sof, eol, eof
  );

  modport slave (
    input  pixel_in, valid_in,
    output pixel_out, valid_out, sof, eol, eof
  );
endinterface

// File: rtl/edge_threshold.sv
// Thresholds a sobel gradient-magnitude frame into an edge map with raster markers and per-frame stats.
// Latency: one cycle from accepted pixel to registered pixel_out/markers; done follows eof by one cycle.
// Backpressure: none; every valid_in in RUN is consumed, and bubbles simply stall the raster counters.
module edge_threshold #(
  parameter  int WIDTH      = 8,
  parameter  int IMG_WIDTH  = 64,
  parameter  int IMG_HEIGHT = 64,
  localparam int CNT_W      = $clog2((IMG_WIDTH - 2) * (IMG_HEIGHT - 2) + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] threshold,
  input  logic             binary_mode,
  edge_threshold_if.slave  bus,
  output logic [CNT_W-1:0] edge_count,
  output logic [WIDTH-1:0] max_mag,
  output logic             busy,
  output logic             done
);

  localparam int OW = IMG_WIDTH - 2;
  localparam int OH = IMG_HEIGHT - 2;
  localparam int XW = (OW > 1) ? $clog2(OW) : 1;
  localparam int YW = (OH > 1) ? $clog2(OH) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(OW - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(OH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [WIDTH-1:0] thr_q;
  logic             bin_q;

  logic             start_ok;
  logic             accept;
  logic             x_last;
  logic             y_last;
  logic             is_edge;
  logic [WIDTH-1:0] pix_next;

  // Decode accepted controls and the thresholded value of the pixel on the bus
  always_comb begin
    start_ok = (state == S_IDLE) && start;
    accept   = (state == S_RUN) && bus.valid_in;
    x_last   = (x == X_LAST);
    y_last   = (y == Y_LAST);
    is_edge  = (bus.pixel_in >= thr_q);
    pix_next = '0;
    if (is_edge) begin
      pix_next = bin_q ? {WIDTH{1'b1}} : bus.pixel_in;
    end
  end

  // Frame FSM: IDLE waits for start, RUN consumes the frame, DONE is a single cycle before IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_RUN;
        S_RUN:   if (accept && x_last && y_last) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Threshold and mode are frozen for the whole frame so mid-frame register writes cannot tear it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q <= '0;
      bin_q <= 1'b0;
    end else if (start_ok) begin
      thr_q <= threshold;
      bin_q <= binary_mode;
    end
  end

  // Raster position of the next pixel; advances only on accepted pixels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (start_ok) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // Frame statistics; held after the frame until the next accepted start clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_count <= '0;
      max_mag    <= '0;
    end else if (start_ok) begin
      edge_count <= '0;
      max_mag    <= '0;
    end else if (accept) begin
      if (is_edge) begin
        edge_count <= edge_count + CNT_W'(1);
      end
      if (bus.pixel_in > max_mag) begin
        max_mag <= bus.pixel_in;
      end
    end
  end

  // Registered output beat; pixel_out is forced to zero on idle cycles to keep the bus quiet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.valid_out <= 1'b0;
      bus.pixel_out <= '0;
      bus.sof       <= 1'b0;
      bus.eol       <= 1'b0;
      bus.eof       <= 1'b0;
    end else begin
      bus.valid_out <= accept;
      bus.pixel_out <= accept ? pix_next : '0;
      bus.sof       <= accept && (x == '0) && (y == '0);
      bus.eol       <= accept && x_last;
      bus.eof       <= accept && x_last && y_last;
    end
  end

  // busy spans start to the DONE cycle; done is registered from DONE so it trails eof by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      if (start_ok) begin
        busy <= 1'b1;
      end else if (state == S_DONE) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_edge_threshold.sv
// Directed bench for edge_threshold: scoreboard of expected output beats plus end-of-frame statistics.
module tb_edge_threshold;

  localparam int NPIX = 62 * 62;

  typedef struct packed {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
    logic       eof;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  threshold;
  logic        binary_mode;
  logic [11:0] edge_count;
  logic [7:0]  max_mag;
  logic        busy;
  logic        done;

  edge_threshold_if #(.WIDTH(8)) bus ();

  edge_threshold #(
    .WIDTH(8),
    .IMG_WIDTH(64),
    .IMG_HEIGHT(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .threshold(threshold),
    .binary_mode(binary_mode),
    .bus(bus),
    .edge_count(edge_count),
    .max_mag(max_mag),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];

  int         k;
  int         exp_cnt;
  int         exp_max;
  logic [7:0] m_thr;
  logic       m_bin;

  int   done_cnt = 0;
  int   sof_cnt  = 0;
  int   eol_cnt  = 0;
  int   eof_cnt  = 0;
  logic prev_eof = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Output monitor: pops the scoreboard on each beat, tracks markers and done timing
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.valid_out) begin
        if (q.size() == 0) begin
          check("spurious_valid_out", bus.valid_out, 1'b0);
        end else begin
          e = q.pop_front();
          check("pixel_out", bus.pixel_out, e.pix);
          check("markers", {bus.sof, bus.eol, bus.eof}, {e.sof, e.eol, e.eof});
        end
        if (bus.sof) sof_cnt++;
        if (bus.eol) eol_cnt++;
        if (bus.eof) eof_cnt++;
      end
      if (done) begin
        done_cnt++;
        check("done_one_after_eof", prev_eof, 1'b1);
      end
      prev_eof = bus.valid_out && bus.eof;
    end else begin
      prev_eof = 1'b0;
    end
  end

  // Start pulse with a junk valid beat on the same edge, which must be ignored
  task automatic do_start(input logic [7:0] thr, input logic bin);
    start          = 1'b1;
    threshold      = thr;
    binary_mode    = bin;
    bus.valid_in   = 1'b1;
    bus.pixel_in   = 8'hEE;
    m_thr   = thr;
    m_bin   = bin;
    k       = 0;
    exp_cnt = 0;
    exp_max = 0;
    sof_cnt = 0;
    eol_cnt = 0;
    eof_cnt = 0;
    @(posedge clk); #1;
    start        = 1'b0;
    bus.valid_in = 1'b0;
    threshold    = $urandom;
    binary_mode  = $urandom;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic send_pixel(input logic [7:0] v, input int bub, input bit start_pulse);
    exp_t e;
    int   x;
    bit   is_e;
    while (bub > 0 && $urandom_range(99) < bub) begin
      bus.valid_in = 1'b0;
      bus.pixel_in = $urandom;
      @(posedge clk); #1;
    end
    x     = k % 62;
    is_e  = (v >= m_thr);
    e.pix = is_e ? (m_bin ? 8'hFF : v) : 8'h00;
    e.sof = (k == 0);
    e.eol = (x == 61);
    e.eof = (k == NPIX - 1);
    q.push_back(e);
    if (is_e) exp_cnt++;
    if (int'(v) > exp_max) exp_max = v;
    k++;
    bus.valid_in = 1'b1;
    bus.pixel_in = v;
    if (start_pulse) begin
      start       = 1'b1;
      threshold   = 8'h00;
      binary_mode = ~m_bin;
    end
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    start        = 1'b0;
  endtask

  // Full frame; const_v < 0 selects the k mod 256 ramp
  task automatic run_frame(input logic [7:0] thr, input logic bin, input int const_v,
                           input int bub, input bit ignored_ctl);
    int done_base;
    done_base = done_cnt;
    do_start(thr, bin);
    for (int i = 0; i < NPIX; i++) begin
      send_pixel((const_v < 0) ? 8'(i % 256) : 8'(const_v), bub, ignored_ctl && (i == 500));
    end
    if (ignored_ctl) begin
      start       = 1'b1;
      threshold   = 8'h05;
      binary_mode = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
        bus.valid_in = 1'b1;
        bus.pixel_in = 8'hFF;
        @(posedge clk); #1;
      end
      bus.valid_in = 1'b0;
    end
    repeat (5) @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    check("done_once", done_cnt - done_base, 1);
    check("sof_count", sof_cnt, 1);
    check("eol_count", eol_cnt, 62);
    check("eof_count", eof_cnt, 1);
    check("edge_count", edge_count, exp_cnt);
    check("max_mag", max_mag, exp_max);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    threshold    = 8'h00;
    binary_mode  = 1'b0;
    bus.valid_in = 1'b0;
    bus.pixel_in = 8'h00;

    // Reset with random inputs: every output must stay at zero
    for (int i = 0; i < 4; i++) begin
      start        = $urandom;
      threshold    = $urandom;
      binary_mode  = $urandom;
      bus.valid_in = $urandom;
      bus.pixel_in = $urandom;
      @(negedge clk);
      check("rst_outputs", {bus.valid_out, bus.sof, bus.eol, bus.eof, busy, done}, 6'b0);
      check("rst_pixel_out", bus.pixel_out, 8'h00);
      check("rst_stats", {edge_count, max_mag}, 20'h0);
    end
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // valid_in without start is ignored
    for (int i = 0; i < 10; i++) begin
      bus.valid_in = 1'b1;
      bus.pixel_in = 8'(200 + i);
      @(posedge clk); #1;
    end
    bus.valid_in = 1'b0;
    #1;
    check("idle_edge_count", edge_count, 0);
    check("idle_max_mag", max_mag, 0);
    check("idle_busy", busy, 1'b0);
    @(posedge clk); #1;

    // Ramp, binary, contiguous
    run_frame(8'd100, 1'b1, -1, 0, 1'b0);
    check("ramp_count_2340", edge_count, 2340);
    check("ramp_max_255", max_mag, 255);
    @(posedge clk); #1;

    // Same ramp with ~30% bubbles
    run_frame(8'd100, 1'b1, -1, 30, 1'b0);
    @(posedge clk); #1;

    // Passthrough with ignored start in RUN and in DONE, plus stray valid_in afterwards
    run_frame(8'd0, 1'b0, 7, 0, 1'b1);
    check("pass_count_3844", edge_count, 3844);
    check("pass_max_7", max_mag, 7);
    @(posedge clk); #1;

    // Threshold at maximum, all pixels just below it
    run_frame(8'd255, 1'b0, 254, 0, 1'b0);
    check("thr255_count_0", edge_count, 0);
    check("thr255_max_254", max_mag, 254);
    @(posedge clk); #1;

    // Abort a frame mid-way with reset
    do_start(8'd100, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      send_pixel(8'd200, 0, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    q.delete();
    check("abort_valid_out", bus.valid_out, 1'b0);
    check("abort_edge_count", edge_count, 0);
    check("abort_max_mag", max_mag, 0);
    check("abort_busy", busy, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fresh frame after the abort must start cleanly at sof
    run_frame(8'd100, 1'b0, 200, 0, 1'b0);
    check("post_abort_count_3844", edge_count, 3844);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
